// File: rtl/kd_tree_pkg.sv
// Shared types and the per-node routing decision for the KD-tree traversal.
package kd_tree_pkg;

    localparam int DSIZE      = 11;
    localparam int NUM_COMP   = 5;
    localparam int TREE_DEPTH = 8;
    localparam int NODE_BITS  = 2 * DSIZE;
    localparam int PATCH_BITS = NUM_COMP * DSIZE;

    typedef struct packed {
        logic signed [DSIZE-1:0] median;
        logic [DSIZE-1:0]        comp_idx;
    } node_t;

    // Component k sits at bits [11k+10:11k].
    typedef logic [NUM_COMP-1:0][DSIZE-1:0] patch_t;

    // 1 = take the right child. Out-of-range component indices always go left.
    function automatic logic go_right(input patch_t patch, input node_t node);
        logic [DSIZE-1:0] comp;
        if (node.comp_idx >= DSIZE'(NUM_COMP)) begin
            return 1'b0;
        end
        comp = patch[node.comp_idx[2:0]];
        return !($signed(comp) < $signed(node.median));
    endfunction

endpackage

// File: rtl/kd_tree_level_stage.sv
// One tree level: its node bank, the routing compare and the stage registers.
module kd_tree_level_stage
    import kd_tree_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [TREE_DEPTH-1:0] wr_addr,
    input  logic [NODE_BITS-1:0]  wr_data,
    input  logic [PATCH_BITS-1:0] patch_in,
    input  logic [TREE_DEPTH-1:0] prefix_in,
    output logic [PATCH_BITS-1:0] patch_out,
    output logic [TREE_DEPTH-1:0] prefix_out
);

    // Level 0 has a single node; give it a 1-bit address to avoid a zero-width index.
    localparam int AW    = (LEVEL == 0) ? 1 : LEVEL;
    localparam int DEPTH = 1 << AW;

    node_t          bank [DEPTH];
    node_t          wr_node;
    node_t          cur_node;
    patch_t         patch;
    logic [AW-1:0]  rd_local;
    logic [AW-1:0]  wr_local;
    logic           decision;

    assign wr_node  = wr_data;
    assign patch    = patch_in;
    assign rd_local = (LEVEL == 0) ? '0 : prefix_in[AW-1:0];
    assign wr_local = (LEVEL == 0) ? '0 : wr_addr[AW-1:0];

    // Combinational read: a node written on this edge is seen by the stage next cycle.
    assign cur_node = bank[rd_local];
    assign decision = go_right(patch, cur_node);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            prefix_out <= '0;
        end else begin
            if (wr_en) begin
                bank[wr_local] <= wr_node;
            end
            if (enable) begin
                prefix_out <= {prefix_in[TREE_DEPTH-2:0], decision};
            end
        end
    end

    generate
        if (LEVEL < TREE_DEPTH - 1) begin : g_patch_reg
            logic [PATCH_BITS-1:0] patch_reg;
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    patch_reg <= '0;
                end else if (enable) begin
                    patch_reg <= patch_in;
                end
            end
            assign patch_out = patch_reg;
        end else begin : g_last
            // Nothing downstream of the last level needs the patch.
            assign patch_out = patch_in;
        end
    endgenerate

endmodule

// File: rtl/kd_tree_internal_nodes.sv
// Depth-8 KD-tree: heap-ordered node loader feeding an 8-stage traversal pipeline.
module kd_tree_internal_nodes
    import kd_tree_pkg::*;
#(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH    = 55,
    parameter int ADDRESS_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fsm_enable,
    input  logic                      sender_enable,
    input  logic [INTERNAL_WIDTH-1:0] sender_data,
    input  logic [PATCH_WIDTH-1:0]    patch_in,
    output logic [ADDRESS_WIDTH-1:0]  leaf_index
);

    logic [TREE_DEPTH-1:0] wptr_reg;
    logic [TREE_DEPTH:0]   wptr_plus1;
    logic [PATCH_BITS-1:0] patch_s  [TREE_DEPTH+1];
    logic [TREE_DEPTH-1:0] prefix_s [TREE_DEPTH+1];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wptr_reg <= '0;
        end else if (sender_enable && (wptr_reg != '1)) begin
            wptr_reg <= wptr_reg + 1'b1;
        end
    end

    // Node n lives in level floor(log2(n+1)) at local index (n+1) - 2^level.
    // Once saturated, n+1 = 256 matches no level, so extra strobes are dropped.
    assign wptr_plus1 = {1'b0, wptr_reg} + 1'b1;

    assign patch_s[0]  = patch_in;
    assign prefix_s[0] = '0;

    generate
        for (genvar gi = 0; gi < TREE_DEPTH; gi++) begin : g_level
            logic level_we;
            assign level_we = sender_enable && ((wptr_plus1 >> gi) == (TREE_DEPTH+1)'(1));

            kd_tree_level_stage #(
                .LEVEL(gi)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .enable     (fsm_enable),
                .wr_en      (level_we),
                .wr_addr    (wptr_plus1[TREE_DEPTH-1:0]),
                .wr_data    (sender_data),
                .patch_in   (patch_s[gi]),
                .prefix_in  (prefix_s[gi]),
                .patch_out  (patch_s[gi+1]),
                .prefix_out (prefix_s[gi+1])
            );
        end
    endgenerate

    assign leaf_index = prefix_s[TREE_DEPTH];

endmodule

// File: tb/tb_kd_tree_internal_nodes.sv
// Directed bench for the KD-tree loader and traversal pipeline.
module tb_kd_tree_internal_nodes;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fsm_enable;
    logic        sender_enable;
    logic [21:0] sender_data;
    logic [54:0] patch_in;
    logic [7:0]  leaf_index;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    kd_tree_internal_nodes dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fsm_enable    (fsm_enable),
        .sender_enable (sender_enable),
        .sender_data   (sender_data),
        .patch_in      (patch_in),
        .leaf_index    (leaf_index)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: leaf_index=%02h", tag, got);
        end
    endtask

    function automatic logic [21:0] nw(input int med, input int idx);
        return {11'(med), 11'(idx)};
    endfunction

    function automatic logic [54:0] pt(input int c0, input int c1);
        logic [54:0] p;
        p = '0;
        p[10:0]  = 11'(c0);
        p[21:11] = 11'(c1);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b1;
        sender_enable = 1'b0;
        fsm_enable    = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic write_word(input logic [21:0] w);
        sender_enable = 1'b1;
        sender_data   = w;
        tick();
        sender_enable = 1'b0;
    endtask

    // Hold a patch for a full pipeline depth, then check the leaf it produced.
    task automatic run_patch(input string tag, input logic [54:0] p, input logic [7:0] exp);
        patch_in   = p;
        fsm_enable = 1'b1;
        repeat (8) tick();
        check_eq(tag, leaf_index, exp);
        fsm_enable = 1'b0;
    endtask

    initial begin
        int v;
        rst_n         = 1'b0;
        fsm_enable    = 1'b0;
        sender_enable = 1'b0;
        sender_data   = '0;
        patch_in      = '0;

        do_reset();
        check_eq("reset_leaf", leaf_index, 8'h00);

        // All-zero tree: comp0 >= 0 goes right at every level.
        for (int k = 0; k < 255; k++) write_word(nw(0, 0));
        run_patch("zero_tree_pos", pt(5, 0), 8'hFF);
        run_patch("zero_tree_neg", pt(-3, 0), 8'h00);

        // Streaming: fill with -3, then alternate, with a 3-cycle stall mid-stream.
        fsm_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            patch_in = pt(-3, 0);
            tick();
            exp_q.push_back(8'h00);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                fsm_enable = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    patch_in = pt((s % 2 == 0) ? 5 : -3, 0);
                    tick();
                    check_eq("stall_hold", leaf_index, exp_q[exp_q.size()-8]);
                end
                fsm_enable = 1'b1;
            end
            v = (i % 2 == 0) ? 5 : -3;
            patch_in = pt(v, 0);
            tick();
            exp_q.push_back((v >= 0) ? 8'hFF : 8'h00);
            check_eq("stream", leaf_index, exp_q[exp_q.size()-8]);
        end
        fsm_enable = 1'b0;

        // First word after reset lands at the root.
        do_reset();
        check_eq("reset_leaf2", leaf_index, 8'h00);
        write_word(nw(2, 1));
        run_patch("root_right", pt(-1, 2), 8'h80);
        run_patch("root_left", pt(-1, 1), 8'h00);

        do_reset();
        run_patch("reset_clears_nodes", pt(-1, 2), 8'h00);

        do_reset();
        write_word(nw(-4, 0));
        run_patch("signed_compare", pt(3, 0), 8'hFF);

        do_reset();
        write_word(nw(-1024, 7));
        run_patch("bad_comp_idx", pt(-1, 0), 8'h00);

        // Node k gets median k; strobes past 255 must not touch node 254.
        do_reset();
        for (int k = 0; k < 260; k++) write_word(nw(k, 0));
        run_patch("path_254", pt(254, 0), 8'hFF);
        run_patch("path_253", pt(253, 0), 8'hFE);
        run_patch("path_100", pt(100, 0), 8'hFC);
        run_patch("path_10", pt(10, 0), 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
